// File: rtl/cv32e40px_instr_obi_arbiter.sv
// cv32e40px_instr_obi_arbiter
// Shares the instruction OBI port between two fetchers, routing in-order responses back.
module cv32e40px_instr_obi_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] owner_q;
    logic [DEPTH-1:0] owner_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    widx;
    logic             lock_q;
    logic             lock_owner_q;
    logic             last_q;
    logic             sel;
    logic             sel_req;
    logic             full;
    logic             push;
    logic             pop;
    logic             head;

    // Pick the master that owns the address phase this cycle
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_owner_q;
        end else if (m0_req_i && m1_req_i) begin
            sel = FIXED_PRIO ? 1'b0 : !last_q;
        end else if (m1_req_i) begin
            sel = 1'b1;
        end
    end

    assign sel_req    = sel ? m1_req_i : m0_req_i;
    assign full       = (count_q == CW'(DEPTH));
    assign mem_req_o  = !rst && sel_req && !full;
    assign mem_addr_o = rst ? '0 : (sel ? m1_addr_i : m0_addr_i);
    assign push       = mem_req_o && mem_gnt_i;
    assign pop        = !rst && mem_rvalid_i && (count_q != '0);
    assign head       = owner_q[0];

    assign m0_gnt_o    = push && !sel;
    assign m1_gnt_o    = push && sel;
    assign m0_rvalid_o = pop && !head;
    assign m1_rvalid_o = pop && head;
    assign m0_err_o    = m0_rvalid_o && mem_err_i;
    assign m1_err_o    = m1_rvalid_o && mem_err_i;
    assign m0_rdata_o  = rst ? '0 : mem_rdata_i;
    assign m1_rdata_o  = rst ? '0 : mem_rdata_i;
    assign busy_o      = !rst && (count_q != '0);

    // Owner FIFO next state: shift out the head on pop, write the new owner at the tail
    always_comb begin
        owner_d = pop ? (owner_q >> 1) : owner_q;
        widx    = pop ? (count_q - CW'(1)) : count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push && (widx == CW'(i))) begin
                owner_d[i] = sel;
            end
        end
    end

    // Owner FIFO storage and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= '0;
            count_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Hold the chosen master across wait states; rotate priority only on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            last_q       <= 1'b1;
        end else begin
            lock_q <= mem_req_o && !mem_gnt_i;
            if (mem_req_o && !mem_gnt_i) begin
                lock_owner_q <= sel;
            end
            if (push) begin
                last_q <= sel;
            end
        end
    end

`ifdef CV32E40P_ASSERT_ON
    property p_addr_stable;
        @(posedge clk) disable iff (rst)
        (mem_req_o && !mem_gnt_i) |=> (!mem_req_o || $stable(mem_addr_o));
    endproperty

    a_addr_stable: assert property (p_addr_stable);

    a_count_max: assert property (
        @(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

    a_no_stray_rvalid: assert property (
        @(posedge clk) disable iff (rst) !(mem_rvalid_i && (count_q == '0)));
`endif

endmodule
